// File: rtl/bp_pht_port_sched_if.sv
// Lookup, update and PHT RAM signals shared by the port scheduler and its environment.
// master = fetch/memory pipeline plus RAM; slave = the scheduler.
interface bp_pht_port_sched_if #(
    parameter int unsigned PHT_DEPTH = 6
);
    logic                 lookup_req;
    logic [PHT_DEPTH-1:0] lookup_index;
    logic                 lookup_gnt;
    logic                 lookup_rvalid;
    logic                 lookup_taken;
    logic                 upd_valid;
    logic [PHT_DEPTH-1:0] upd_index;
    logic                 upd_taken;
    logic                 upd_ready;
    logic                 ram_en;
    logic                 ram_we;
    logic [PHT_DEPTH-1:0] ram_addr;
    logic [1:0]           ram_wdata;
    logic [1:0]           ram_rdata;

    modport master (
        output lookup_req, lookup_index, upd_valid, upd_index, upd_taken, ram_rdata,
        input  lookup_gnt, lookup_rvalid, lookup_taken, upd_ready,
               ram_en, ram_we, ram_addr, ram_wdata
    );

    modport slave (
        input  lookup_req, lookup_index, upd_valid, upd_index, upd_taken, ram_rdata,
        output lookup_gnt, lookup_rvalid, lookup_taken, upd_ready,
               ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/bp_pht_port_sched.sv
// Single-port PHT RAM scheduler: init sweep, lookup/update arbitration, update FIFO + RMW.
// Define BP_SCHED_PERF_EN to add the perf_drop / perf_upd / perf_lkstall counters.
module bp_pht_port_sched #(
    parameter int unsigned PHT_DEPTH = 6,
    parameter int unsigned QDEPTH    = 4,
    parameter logic [1:0]  INIT_VAL  = 2'b01
) (
    input  logic                     clk,
    input  logic                     rst,
    bp_pht_port_sched_if.slave       bus,
    output logic                     busy_init,
    output logic [$clog2(QDEPTH):0]  q_count
`ifdef BP_SCHED_PERF_EN
    ,
    output logic [31:0]              perf_drop,
    output logic [31:0]              perf_upd,
    output logic [31:0]              perf_lkstall
`endif
);
    localparam int unsigned PW = $clog2(QDEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {INIT, IDLE, UPD_WR} state_t;

    state_t               state, state_nxt;
    logic [PHT_DEPTH-1:0] init_cnt;
    logic [PHT_DEPTH-1:0] q_index [QDEPTH];
    logic [QDEPTH-1:0]    q_taken;
    logic [PW-1:0]        head, tail;
    logic                 push, pop, q_full, q_empty;
    logic                 gnt, en, we, rvalid;
    logic [PHT_DEPTH-1:0] addr;
    logic [1:0]           wdata, rmw_val;

    assign q_full  = (q_count == CW'(QDEPTH));
    assign q_empty = (q_count == '0);
    assign push    = bus.upd_valid & bus.upd_ready;
    assign pop     = (state == UPD_WR);

    // Saturating 2-bit counter step for the head entry, applied to the value read last cycle.
    always_comb begin
        if (q_taken[head]) rmw_val = (bus.ram_rdata == 2'b11) ? 2'b11 : bus.ram_rdata + 2'b01;
        else               rmw_val = (bus.ram_rdata == 2'b00) ? 2'b00 : bus.ram_rdata - 2'b01;
    end

    // NOTE: every output of this block is given a default first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        gnt       = 1'b0;
        en        = 1'b0;
        we        = 1'b0;
        addr      = '0;
        wdata     = '0;
        unique case (state)
            INIT: begin
                en    = 1'b1;
                we    = 1'b1;
                addr  = init_cnt;
                wdata = INIT_VAL;
                if (init_cnt == '1) state_nxt = IDLE;
            end
            IDLE: begin
                // A full FIFO outranks fetch so training cannot be starved forever.
                if (q_full || (!bus.lookup_req && !q_empty)) begin
                    en        = 1'b1;
                    addr      = q_index[head];
                    state_nxt = UPD_WR;
                end else if (bus.lookup_req) begin
                    gnt  = 1'b1;
                    en   = 1'b1;
                    addr = bus.lookup_index;
                end
            end
            UPD_WR: begin
                en        = 1'b1;
                we        = 1'b1;
                addr      = q_index[head];
                wdata     = rmw_val;
                state_nxt = IDLE;
            end
            default: state_nxt = INIT;
        endcase
    end

    // RAM strobes are forced low while reset is held so an in-flight write is abandoned at once.
    assign bus.ram_en       = en & rst;
    assign bus.ram_we       = we & rst;
    assign bus.ram_addr     = rst ? addr  : '0;
    assign bus.ram_wdata    = rst ? wdata : '0;
    assign bus.lookup_gnt   = gnt;
    assign bus.lookup_rvalid = rvalid;
    assign bus.lookup_taken = rvalid & bus.ram_rdata[1];
    assign bus.upd_ready    = !q_full;
    assign busy_init        = (state == INIT);

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= INIT;
            init_cnt <= '0;
            rvalid   <= 1'b0;
        end else begin
            state  <= state_nxt;
            rvalid <= gnt;
            if (state == INIT) init_cnt <= init_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head    <= '0;
            tail    <= '0;
            q_count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            unique case ({push, pop})
                2'b10:   q_count <= q_count + 1'b1;
                2'b01:   q_count <= q_count - 1'b1;
                default: q_count <= q_count;
            endcase
        end
    end

    // NOTE: FIFO payload is not reset; occupancy alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            q_index[tail] <= bus.upd_index;
            q_taken[tail] <= bus.upd_taken;
        end
    end

`ifdef BP_SCHED_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_drop    <= '0;
            perf_upd     <= '0;
            perf_lkstall <= '0;
        end else begin
            if (bus.upd_valid && !bus.upd_ready) perf_drop    <= perf_drop + 32'd1;
            if (state == UPD_WR)                 perf_upd     <= perf_upd + 32'd1;
            if (bus.lookup_req && !gnt)          perf_lkstall <= perf_lkstall + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_bp_pht_port_sched.sv
// Scoreboard bench for bp_pht_port_sched: a rule-level model predicts every RAM access,
// lookup result and FIFO occupancy; a monitor compares them on the falling edge.
module tb_bp_pht_port_sched;
    localparam int         PHT_DEPTH = 6;
    localparam int         QDEPTH    = 4;
    localparam int         NENT      = 1 << PHT_DEPTH;
    localparam logic [1:0] INIT_VAL  = 2'b01;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       busy_init;
    logic [2:0] q_count;
`ifdef BP_SCHED_PERF_EN
    logic [31:0] perf_drop, perf_upd, perf_lkstall;
`endif

    bp_pht_port_sched_if #(.PHT_DEPTH(PHT_DEPTH)) bus ();

    bp_pht_port_sched #(.PHT_DEPTH(PHT_DEPTH), .QDEPTH(QDEPTH), .INIT_VAL(INIT_VAL)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .busy_init (busy_init),
        .q_count   (q_count)
`ifdef BP_SCHED_PERF_EN
        ,
        .perf_drop    (perf_drop),
        .perf_upd     (perf_upd),
        .perf_lkstall (perf_lkstall)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM behind the scheduler.
    logic [1:0] ram [NENT];
    always @(posedge clk) begin
        if (bus.ram_en) begin
            if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
            else            bus.ram_rdata     <= ram[bus.ram_addr];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input bit taken);
        if (taken) return (v < 3) ? v + 1 : 3;
        return (v > 0) ? v - 1 : 0;
    endfunction

    typedef struct {
        int idx;
        int val;
    } upd_t;

    // Reference state: mdl = table after every accepted update; committed = table the RAM holds now.
    upd_t exp_q[$];
    int   mdl [NENT];
    int   committed [NENT];
    int   init_idx, occ, prev_rd_addr, lk_pending;
    bit   prev_gnt, prev_rd, exp_gnt, exp_rd;
    int   n_drop, n_upd, n_stall;

    always @(negedge clk) begin
        if (!rst) begin
            check("reset_ram_en", 32'(bus.ram_en), 0);
            check("reset_ram_we", 32'(bus.ram_we), 0);
            check("reset_rvalid", 32'(bus.lookup_rvalid), 0);
            check("reset_q_count", 32'(q_count), 0);
            check("reset_busy_init", 32'(busy_init), 1);
            init_idx = 0;
            prev_gnt = 0;
            prev_rd  = 0;
            n_drop   = 0;
            n_upd    = 0;
            n_stall  = 0;
            exp_q.delete();
            for (int i = 0; i < NENT; i++) mdl[i] = INIT_VAL;
        end else begin
            occ     = exp_q.size();
            exp_gnt = 0;
            exp_rd  = 0;
            if (prev_gnt) begin
                check("lk_rvalid", 32'(bus.lookup_rvalid), 1);
                check("lk_taken", 32'(bus.lookup_taken), lk_pending);
            end else begin
                check("lk_rvalid_idle", 32'(bus.lookup_rvalid), 0);
                check("lk_taken_idle", 32'(bus.lookup_taken), 0);
            end
            if (init_idx < NENT) begin
                check("init_busy", 32'(busy_init), 1);
                check("init_en_we", 32'({bus.ram_en, bus.ram_we}), 3);
                check("init_addr", 32'(bus.ram_addr), init_idx);
                check("init_data", 32'(bus.ram_wdata), INIT_VAL);
                check("init_gnt", 32'(bus.lookup_gnt), 0);
                committed[init_idx] = INIT_VAL;
                init_idx++;
            end else begin
                check("busy_after_init", 32'(busy_init), 0);
                if (prev_rd) begin
                    check("rmw_en_we", 32'({bus.ram_en, bus.ram_we}), 3);
                    check("rmw_addr", 32'(bus.ram_addr), prev_rd_addr);
                    check("rmw_gnt", 32'(bus.lookup_gnt), 0);
                    check("rmw_data", 32'(bus.ram_wdata), exp_q[0].val);
                    committed[exp_q[0].idx] = exp_q[0].val;
                    void'(exp_q.pop_front());
                    n_upd++;
                end else if (occ == QDEPTH || (occ > 0 && !bus.lookup_req)) begin
                    exp_rd       = 1;
                    prev_rd_addr = exp_q[0].idx;
                    check("upd_rd_en_we", 32'({bus.ram_en, bus.ram_we}), 2);
                    check("upd_rd_addr", 32'(bus.ram_addr), prev_rd_addr);
                    check("upd_rd_gnt", 32'(bus.lookup_gnt), 0);
                end else if (bus.lookup_req) begin
                    exp_gnt    = 1;
                    lk_pending = committed[bus.lookup_index] >> 1;
                    check("lk_gnt", 32'(bus.lookup_gnt), 1);
                    check("lk_en_we", 32'({bus.ram_en, bus.ram_we}), 2);
                    check("lk_addr", 32'(bus.ram_addr), 32'(bus.lookup_index));
                end else begin
                    check("idle_ram_en", 32'(bus.ram_en), 0);
                    check("idle_gnt", 32'(bus.lookup_gnt), 0);
                end
            end
            check("q_count", 32'(q_count), occ);
            check("upd_ready", 32'(bus.upd_ready), (occ < QDEPTH) ? 1 : 0);
            if (bus.lookup_req && !exp_gnt) n_stall++;
            if (bus.upd_valid) begin
                if (occ < QDEPTH) begin
                    mdl[bus.upd_index] = sat(mdl[bus.upd_index], bus.upd_taken);
                    exp_q.push_back('{idx: int'(bus.upd_index), val: mdl[bus.upd_index]});
                end else begin
                    n_drop++;
                end
            end
            prev_gnt = exp_gnt;
            prev_rd  = exp_rd;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input int idx, input bit taken);
        bus.upd_valid = 1'b1;
        bus.upd_index = PHT_DEPTH'(idx);
        bus.upd_taken = taken;
        tick();
        bus.upd_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.lookup_req = 1'b0;
        bus.upd_valid  = 1'b0;
        repeat (n) tick();
    endtask

`ifdef BP_SCHED_PERF_EN
    task automatic check_perf();
        check("perf_drop", perf_drop, n_drop);
        check("perf_upd", perf_upd, n_upd);
        check("perf_lkstall", perf_lkstall, n_stall);
    endtask
`endif

    initial begin
        bit found;
        bus.lookup_req   = 1'b0;
        bus.lookup_index = '0;
        bus.upd_valid    = 1'b0;
        bus.upd_index    = '0;
        bus.upd_taken    = 1'b0;
        repeat (3) tick();
        rst = 1'b1;

        // Init sweep with fetch asking every cycle; one update is queued mid-sweep.
        bus.lookup_req = 1'b1;
        for (int c = 0; c < 70; c++) begin
            bus.lookup_index = PHT_DEPTH'($urandom_range(0, NENT - 1));
            bus.upd_valid    = (c == 10);
            bus.upd_index    = 6'd3;
            bus.upd_taken    = 1'b1;
            tick();
        end
        idle(4);

        // Lone taken updates on index 5 walk 01 -> 10 -> 11 and saturate; then look it up.
        for (int k = 0; k < 4; k++) begin
            push_one(5, 1'b1);
            idle(3);
        end
        bus.lookup_req   = 1'b1;
        bus.lookup_index = 6'd5;
        tick();
        idle(2);
        push_one(9, 1'b0);
        idle(3);

        // Fetch held busy: two updates wait, then drain once fetch goes quiet.
        bus.lookup_req = 1'b1;
        push_one(7, 1'b1);
        push_one(8, 1'b0);
        repeat (4) tick();
        idle(6);

        // Five back-to-back updates under constant fetch: the fifth finds the FIFO full.
        bus.lookup_req = 1'b1;
        for (int k = 0; k < 5; k++) push_one($urandom_range(0, 15), 1'($urandom_range(0, 1)));
        repeat (6) tick();
        idle(12);
`ifdef BP_SCHED_PERF_EN
        check_perf();
`endif

        // Reset asserted during an RMW write.
        push_one(12, 1'b1);
        found = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (bus.ram_en && bus.ram_we && !busy_init) found = 1;
        end
        check("rmw_write_seen", 32'(found), 1);
        #1 rst = 1'b0;
        #1;
        check("mid_rmw_reset_we", 32'(bus.ram_we), 0);
        check("mid_rmw_reset_q_count", 32'(q_count), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        bus.lookup_req = 1'b1;
        repeat (66) tick();

        // Randomised traffic on a narrow index range to provoke saturation and full FIFOs.
        for (int c = 0; c < 2000; c++) begin
            bus.lookup_req   = ($urandom_range(0, 99) < 60);
            bus.lookup_index = PHT_DEPTH'($urandom_range(0, 15));
            bus.upd_valid    = ($urandom_range(0, 99) < 40);
            bus.upd_index    = PHT_DEPTH'($urandom_range(0, 15));
            bus.upd_taken    = 1'($urandom_range(0, 1));
            tick();
        end
        idle(20);
        check("drain_empty", exp_q.size(), 0);
        check("drain_q_count", 32'(q_count), 0);
`ifdef BP_SCHED_PERF_EN
        check_perf();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bp_pht_port_sched.md
Name: bp_pht_port_sched

Overview:
- Scheduler for a single-ported 2-bit-counter PHT RAM that is shared between F-stage prediction lookups and M-stage resolved-branch updates.
- Runs the post-reset table initialisation sweep.
- Arbitrates each cycle between a lookup and the read-modify-write (RMW) of the oldest queued update.
- Buffers M-stage updates in a small FIFO so that fetch is never stalled by training.

Parameters:
PHT_DEPTH, 6, index width; table holds 2^PHT_DEPTH entries
QDEPTH, 4, update FIFO depth (power of 2, >=2)
INIT_VAL, 2'b01, counter value written during the init sweep (weakly not-taken)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
lookup_req  in  1  F-stage requests a prediction read this cycle
lookup_index  in  PHT_DEPTH  table index for the lookup
lookup_gnt  out  1  lookup owns the RAM port this cycle
lookup_rvalid  out  1  registered lookup_gnt; lookup_taken is valid
lookup_taken  out  1  ram_rdata[1] when lookup_rvalid=1, else 0
upd_valid  in  1  resolved branch from M stage (branchM & ~flushM)
upd_index  in  PHT_DEPTH  index of the resolved branch
upd_taken  in  1  actual outcome
upd_ready  out  1  FIFO can accept (q_count < QDEPTH)
ram_en  out  1  RAM access enable
ram_we  out  1  RAM write enable
ram_addr  out  PHT_DEPTH  RAM address
ram_wdata  out  2  RAM write data
ram_rdata  in  2  RAM read data, valid one cycle after a read (synchronous RAM)
busy_init  out  1  init sweep in progress
q_count  out  log2(QDEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst=0, asynchronous): state=INIT, init_cnt=0, FIFO empty, lookup_rvalid=0, all RAM outputs 0. busy_init=1 from reset release.
- States: INIT, IDLE, UPD_WR.
- INIT:
  - ram_en=ram_we=1, ram_addr=init_cnt, ram_wdata=INIT_VAL; init_cnt increments each cycle.
  - After address 2^PHT_DEPTH-1 is written, go to IDLE. busy_init drops in the first IDLE cycle.
  - lookup_gnt=0 throughout INIT. Updates are still accepted into the FIFO.
- IDLE priority, evaluated each cycle:
  - (1) FIFO full and non-empty: issue a read of the head entry (ram_en=1, ram_we=0, ram_addr=head.index), lookup_gnt=0, go to UPD_WR.
  - (2) Otherwise, if lookup_req: lookup_gnt=1, read lookup_index, stay in IDLE.
  - (3) Otherwise, if FIFO non-empty: same as (1).
  - (4) Otherwise: ram_en=0.
- UPD_WR:
  - ram_en=ram_we=1, ram_addr=head.index.
  - ram_wdata = saturating update of ram_rdata, plain binary: taken increments, saturating at 3; not-taken decrements, saturating at 0.
  - Pop the head and return to IDLE. lookup_gnt=0 in this cycle.
  - An RMW is never split; a lookup arriving during UPD_WR waits one cycle.
- Update latency: a lone update with no lookup traffic is written two cycles after it is pushed.
- lookup_rvalid is lookup_gnt delayed by one cycle. lookup_taken is ram_rdata[1] gated by lookup_rvalid.
- FIFO push: on upd_valid && upd_ready.
  - If upd_valid && !upd_ready, the update is dropped silently. This is a permitted loss of training, not an error.
  - upd_ready ignores a pop happening in the same cycle.
  - Push and pop in the same cycle: q_count is unchanged.
- Pointers wrap modulo QDEPTH. q_count saturates at QDEPTH by construction.
- No address hazard handling: a lookup may read a stale counter that has a pending update.
- Reset asserted mid-RMW: the write is abandoned, the FIFO is cleared, and the init sweep restarts.

Optional Feature:
BP_SCHED_PERF_EN: adds output ports perf_drop[31:0], perf_upd[31:0] and perf_lkstall[31:0], all reset to 0, each wrapping at 2^32.
- perf_drop increments on each dropped update.
- perf_upd increments on each UPD_WR cycle.
- perf_lkstall increments on each cycle with lookup_req=1 && lookup_gnt=0.
- Without the macro, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
1. Release reset with PHT_DEPTH=6 and lookup_req=1 -> 64 consecutive writes to addr 0..63 with data 01, lookup_gnt=0 throughout; busy_init=0 and lookup_gnt=1 on the 65th cycle.
2. After init, push idx 5 taken with no lookups -> read addr 5, next cycle write 2'b10. Three more taken pushes -> 2'b11, 2'b11, 2'b11 (saturation). A later lookup of idx 5 -> lookup_taken=1 one cycle after grant.
3. Hold lookup_req=1 and push 2 updates -> lookup_gnt=1 every cycle, q_count stays 2. Drop lookup_req -> FIFO drains in 4 cycles, q_count 2->1->0.
4. Hold lookup_req=1 and push 5 updates back-to-back with QDEPTH=4 -> 5th sees upd_ready=0 and is dropped, q_count=4. Next cycle lookup_gnt=0 and the head RMW is issued.
5. Assert rst during UPD_WR -> ram_we falls to 0 immediately. After release, q_count=0 and a full 64-cycle init sweep is repeated.
6. With BP_SCHED_PERF_EN, replay scenario 4 -> perf_drop=1, perf_lkstall>=2, and perf_upd equals the number of RMW writes completed.
